// File: rtl/axis_noc_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : axis_noc_arbiter_if
// Brief   : AXI-Stream bundle between NREQ requesters, the arbiter and the NoC.
// Revision: 1.0 - initial release
// ============================================================================
interface axis_noc_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DATAW = 128,
  parameter int IDW   = 4,
  parameter int DESTW = 12,
  parameter int USERW = 75
);
  logic [NREQ-1:0]       s_tvalid;
  logic [NREQ-1:0]       s_tready;
  logic [NREQ*DATAW-1:0] s_tdata;
  logic [NREQ*DESTW-1:0] s_tdest;
  logic [NREQ*USERW-1:0] s_tuser;
  logic [NREQ-1:0]       s_tlast;

  logic                  m_tvalid;
  logic                  m_tready;
  logic [DATAW-1:0]      m_tdata;
  logic                  m_tlast;
  logic [IDW-1:0]        m_tid;
  logic [DESTW-1:0]      m_tdest;
  logic [USERW-1:0]      m_tuser;

  // slave is the arbiter's view; master is the surrounding requesters plus NoC
  modport slave (
    input  s_tvalid, s_tdata, s_tdest, s_tuser, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast, m_tid, m_tdest, m_tuser
  );

  modport master (
    output s_tvalid, s_tdata, s_tdest, s_tuser, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast, m_tid, m_tdest, m_tuser
  );
endinterface
`default_nettype wire

// File: rtl/axis_noc_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : axis_noc_arbiter
// Brief   : Packet-locked round-robin arbiter muxing NREQ AXI-Stream sources
//           onto one registered NoC ingress port.
// Revision: 1.0 - initial release
// ============================================================================
module axis_noc_arbiter #(
  parameter int NREQ  = 4,
  parameter int DATAW = 128,
  parameter int IDW   = 4,
  parameter int DESTW = 12,
  parameter int USERW = 75
) (
  input  wire              clk,
  input  wire              reset_n,
  axis_noc_arbiter_if.slave s,
  output logic [NREQ-1:0]  grant,
  output logic [15:0]      pkt_count
);

  localparam logic [0:0] C_ST_IDLE   = 1'b0;
  localparam logic [0:0] C_ST_LOCKED = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [15:0]      pkt_count_q, pkt_count_d;

  logic             m_tvalid_q;
  logic [DATAW-1:0] m_tdata_q;
  logic             m_tlast_q;
  logic [IDW-1:0]   m_tid_q;
  logic [DESTW-1:0] m_tdest_q;
  logic [USERW-1:0] m_tuser_q;

  logic [IDW-1:0]   pick;
  int               arb_dist;
  int               arb_best;
  logic             any_valid;
  logic             own_valid;
  logic             own_last;
  logic [DATAW-1:0] own_data;
  logic [DESTW-1:0] own_dest;
  logic [USERW-1:0] own_user;
  logic             out_free;
  logic             accept;
  logic             pkt_end;
  logic [NREQ-1:0]  s_tready_w;

  assign any_valid = |s.s_tvalid;

  // Rotating priority: distance 0 is the requester just after last_grant.
  always_comb begin
    pick     = '0;
    arb_best = NREQ;
    arb_dist = 0;
    for (int i = 0; i < NREQ; i++) begin
      arb_dist = (i + NREQ - 1 - int'(last_grant_q)) % NREQ;
      if (s.s_tvalid[i] && (arb_dist < arb_best)) begin
        arb_best = arb_dist;
        pick     = IDW'(i);
      end
    end
  end

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    own_dest  = '0;
    own_user  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IDW'(i)) begin
        own_valid = s.s_tvalid[i];
        own_last  = s.s_tlast[i];
        own_data  = s.s_tdata[i*DATAW +: DATAW];
        own_dest  = s.s_tdest[i*DESTW +: DESTW];
        own_user  = s.s_tuser[i*USERW +: USERW];
      end
    end
  end

  assign out_free = !m_tvalid_q || s.m_tready;
  assign accept   = (state_q == C_ST_LOCKED) && own_valid && out_free;
  assign pkt_end  = accept && own_last;

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= C_ST_IDLE;
      owner_q      <= '0;
      last_grant_q <= IDW'(NREQ - 1);
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    case (state_q)
      C_ST_IDLE: begin
        if (any_valid) begin
          state_d = C_ST_LOCKED;
          owner_d = pick;
        end
      end
      C_ST_LOCKED: begin
        if (pkt_end) begin
          state_d      = C_ST_IDLE;
          last_grant_d = owner_q;
        end
      end
      default: state_d = C_ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    s_tready_w = '0;
    grant      = '0;
    if (state_q == C_ST_LOCKED) begin
      for (int i = 0; i < NREQ; i++) begin
        if (owner_q == IDW'(i)) begin
          s_tready_w[i] = out_free;
          grant[i]      = 1'b1;
        end
      end
    end
  end

  // Output register holds everything stable while the NoC back-pressures.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tid_q    <= '0;
      m_tdest_q  <= '0;
      m_tuser_q  <= '0;
    end else if (accept) begin
      m_tvalid_q <= 1'b1;
      m_tdata_q  <= own_data;
      m_tlast_q  <= own_last;
      m_tid_q    <= owner_q;
      m_tdest_q  <= own_dest;
      m_tuser_q  <= own_user;
    end else if (s.m_tready) begin
      m_tvalid_q <= 1'b0;
    end
  end

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (pkt_end) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end

  assign s.s_tready = s_tready_w;
  assign s.m_tvalid = m_tvalid_q;
  assign s.m_tdata  = m_tdata_q;
  assign s.m_tlast  = m_tlast_q;
  assign s.m_tid    = m_tid_q;
  assign s.m_tdest  = m_tdest_q;
  assign s.m_tuser  = m_tuser_q;
  assign pkt_count  = pkt_count_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_noc_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_axis_noc_arbiter
// Brief   : Self-checking bench: arbitration vectors, scoreboarded data path,
//           multi-beat, stall, rotation, async reset and counter wrap cases.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axis_noc_arbiter;

  localparam int NREQ  = 4;
  localparam int DATAW = 128;
  localparam int IDW   = 4;
  localparam int DESTW = 12;
  localparam int USERW = 75;
  localparam int OW    = DATAW + DESTW + USERW + IDW + 1;

  typedef struct packed {
    logic [DATAW-1:0] data;
    logic [DESTW-1:0] dest;
    logic [USERW-1:0] user;
    logic             last;
  } beat_t;

  typedef struct packed {
    beat_t          b;
    logic [IDW-1:0] id;
  } sb_t;

  typedef struct packed {
    logic [NREQ-1:0] mask;
    int              n;
    logic [3:0][3:0] tids;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NREQ-1:0] grant;
  logic [15:0]     pkt_count;

  axis_noc_arbiter_if #(.NREQ(NREQ), .DATAW(DATAW), .IDW(IDW), .DESTW(DESTW), .USERW(USERW)) bus ();

  axis_noc_arbiter #(.NREQ(NREQ), .DATAW(DATAW), .IDW(IDW), .DESTW(DESTW), .USERW(USERW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s        (bus.slave),
    .grant    (grant),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  beat_t           rq[NREQ][$];
  sb_t             sb[$];
  logic [IDW-1:0]  out_tid[$];
  logic [7:0]      out_byte[$];
  logic [NREQ-1:0] grant_log[$];
  logic [NREQ-1:0] acc;
  logic [NREQ-1:0] prev_grant;
  logic [OW-1:0]   prev_out;
  bit              hold_prev;
  bit              watch3;
  bit              mrdy;
  int cyc, first_v, first_m, last_m, vcnt, stab_err, rdy_err, leg_err, r3_err;
  int n_chk = 0;
  int n_pass = 0;
  vec_t vt[6];

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic beat_t mk_beat(int req, int val, bit last);
    beat_t b;
    b.data = {32'($urandom), 32'($urandom), 32'(req), 32'(val)};
    b.dest = DESTW'(req * 16 + val);
    b.user = {11'(req), 32'($urandom), 32'($urandom)};
    b.last = last;
    return b;
  endfunction

  function automatic vec_t mkv(logic [3:0] m, int n, logic [3:0] a, logic [3:0] b,
                               logic [3:0] c, logic [3:0] d);
    vec_t v;
    v.mask = m;
    v.n = n;
    v.tids[0] = a;
    v.tids[1] = b;
    v.tids[2] = c;
    v.tids[3] = d;
    return v;
  endfunction

  function automatic bit busy();
    for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) return 1'b1;
    return (sb.size() > 0) || bus.m_tvalid;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    end
    acc = '0;
    for (int i = 0; i < NREQ; i++) begin
      beat_t h;
      h = (rq[i].size() > 0) ? rq[i][0] : '0;
      bus.s_tvalid[i] = (rq[i].size() > 0);
      bus.s_tdata[i*DATAW +: DATAW] = h.data;
      bus.s_tdest[i*DESTW +: DESTW] = h.dest;
      bus.s_tuser[i*USERW +: USERW] = h.user;
      bus.s_tlast[i] = h.last;
    end
    bus.m_tready = mrdy;
  endtask

  task automatic monitor();
    logic [OW-1:0] cur;
    sb_t e;
    cur = {bus.m_tdata, bus.m_tdest, bus.m_tuser, bus.m_tlast, bus.m_tid};
    if (hold_prev && bus.m_tvalid && (cur != prev_out)) stab_err++;
    if (bus.m_tvalid && !bus.m_tready && (bus.s_tready != '0)) rdy_err++;
    if ((bus.s_tready & ~grant) != '0) leg_err++;
    hold_prev = bus.m_tvalid && !bus.m_tready;
    prev_out  = cur;
    if (bus.m_tvalid) begin
      vcnt++;
      if (first_m < 0) first_m = cyc;
      last_m = cyc;
    end
    if (first_v < 0 && bus.s_tvalid != '0) first_v = cyc;
    if (watch3 && bus.s_tready[3] && rq[1].size() > 0) r3_err++;
    if (grant != '0 && grant != prev_grant) grant_log.push_back(grant);
    prev_grant = grant;
    if (bus.m_tvalid && bus.m_tready) begin
      out_tid.push_back(bus.m_tid);
      out_byte.push_back(bus.m_tdata[7:0]);
      chk("sb_nonempty", 256'(sb.size() != 0), 256'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_beat", 256'(cur), 256'(e));
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (bus.s_tvalid[i] && bus.s_tready[i]) begin
        acc[i] = 1'b1;
        sb.push_back({rq[i][0], IDW'(i)});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drive();
    @(negedge clk);
    monitor();
  endtask

  task automatic run_idle(int budget);
    int k;
    k = 0;
    while (busy() && k < budget) begin
      tick();
      k++;
    end
    chk("drain_timeout", 256'(k < budget), 256'(1));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    sb.delete();
    out_tid.delete();
    out_byte.delete();
    grant_log.delete();
    acc = '0; prev_grant = '0; prev_out = '0; hold_prev = 1'b0; watch3 = 1'b0; mrdy = 1'b1;
    cyc = 0; first_v = -1; first_m = -1; last_m = -1;
    vcnt = 0; stab_err = 0; rdy_err = 0; leg_err = 0; r3_err = 0;
    bus.s_tvalid = '0; bus.s_tdata = '0; bus.s_tdest = '0; bus.s_tuser = '0;
    bus.s_tlast = '0; bus.m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] oh;
    int k;

    vt[0] = mkv(4'b0101, 2, 4'd0, 4'd2, 4'd0, 4'd0);
    vt[1] = mkv(4'b1111, 4, 4'd0, 4'd1, 4'd2, 4'd3);
    vt[2] = mkv(4'b1010, 2, 4'd1, 4'd3, 4'd0, 4'd0);
    vt[3] = mkv(4'b1000, 1, 4'd3, 4'd0, 4'd0, 4'd0);
    vt[4] = mkv(4'b0110, 2, 4'd1, 4'd2, 4'd0, 4'd0);
    vt[5] = mkv(4'b1101, 3, 4'd0, 4'd2, 4'd3, 4'd0);

    // Arbitration vectors: simultaneous single-beat packets straight after reset
    for (int v = 0; v < 6; v++) begin
      do_reset();
      chk("rst_m_tvalid", 256'(bus.m_tvalid), 256'(0));
      chk("rst_grant", 256'(grant), 256'(0));
      chk("rst_pkt_count", 256'(pkt_count), 256'(0));
      chk("rst_s_tready", 256'(bus.s_tready), 256'(0));
      for (int i = 0; i < NREQ; i++)
        if (vt[v].mask[i]) rq[i].push_back(mk_beat(i, 16 * v + i, 1'b1));
      run_idle(40);
      chk("vec_pkt_count", 256'(pkt_count), 256'(vt[v].n));
      chk("vec_nout", 256'(out_tid.size()), 256'(vt[v].n));
      for (int j = 0; j < vt[v].n; j++) begin
        oh = '0;
        oh[vt[v].tids[j]] = 1'b1;
        chk("vec_tid", 256'(out_tid[j]), 256'(vt[v].tids[j]));
        chk("vec_grant", 256'(grant_log[j]), 256'(oh));
      end
      chk("vec_latency", 256'(first_m - first_v), 256'(2));
      chk("vec_ready_legal", 256'(leg_err), 256'(0));
    end

    // Four-beat packet on requester 1 must not be interleaved with requester 3
    do_reset();
    watch3 = 1'b1;
    for (int j = 0; j < 4; j++) rq[1].push_back(mk_beat(1, 8'hA0 + j, j == 3));
    rq[3].push_back(mk_beat(3, 8'hB0, 1'b1));
    run_idle(40);
    chk("lock_r3_ready", 256'(r3_err), 256'(0));
    chk("lock_nout", 256'(out_byte.size()), 256'(5));
    for (int j = 0; j < 4; j++) chk("lock_order", 256'(out_byte[j]), 256'(8'hA0 + j));
    chk("lock_order_r3", 256'(out_byte[4]), 256'(8'hB0));
    chk("lock_pkt_count", 256'(pkt_count), 256'(2));

    // Five cycles of NoC back-pressure in the middle of a packet
    do_reset();
    for (int j = 0; j < 4; j++) rq[0].push_back(mk_beat(0, 8'h30 + j, j == 3));
    k = 0;
    while (out_byte.size() < 1 && k < 20) begin tick(); k++; end
    chk("stall_start_timeout", 256'(k < 20), 256'(1));
    mrdy = 1'b0;
    repeat (5) tick();
    chk("stall_hold_valid", 256'(bus.m_tvalid), 256'(1));
    mrdy = 1'b1;
    run_idle(40);
    chk("stall_stable", 256'(stab_err), 256'(0));
    chk("stall_no_ready", 256'(rdy_err), 256'(0));
    chk("stall_nout", 256'(out_byte.size()), 256'(4));
    for (int j = 0; j < 4; j++) chk("stall_order", 256'(out_byte[j]), 256'(8'h30 + j));
    chk("stall_pkt_count", 256'(pkt_count), 256'(1));

    // All requesters busy: fair rotation and one idle cycle per packet
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) rq[i].push_back(mk_beat(i, 8'h40 + 4 * r + i, 1'b1));
    run_idle(60);
    for (int j = 0; j < 8; j++) chk("rot_tid", 256'(out_tid[j]), 256'(j % NREQ));
    chk("rot_valid_cycles", 256'(vcnt), 256'(8));
    chk("rot_span", 256'(last_m - first_m), 256'(14));
    chk("rot_pkt_count", 256'(pkt_count), 256'(8));

    // Asynchronous reset during beat 2 of a three-beat packet
    do_reset();
    rq[3].push_back(mk_beat(3, 8'h50, 1'b1));
    run_idle(20);
    chk("arst_pre_count", 256'(pkt_count), 256'(1));
    out_tid.delete();
    out_byte.delete();
    for (int j = 0; j < 3; j++) rq[0].push_back(mk_beat(0, 8'h60 + j, j == 2));
    rq[2].push_back(mk_beat(2, 8'h70, 1'b1));
    k = 0;
    while (out_byte.size() < 2 && k < 20) begin tick(); k++; end
    chk("arst_setup", 256'(out_byte[1]), 256'(8'h61));
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_m_tvalid", 256'(bus.m_tvalid), 256'(0));
    chk("arst_pkt_count", 256'(pkt_count), 256'(0));
    chk("arst_grant", 256'(grant), 256'(0));
    do_reset();
    repeat (3) tick();
    chk("arst_quiet", 256'(vcnt), 256'(0));
    rq[3].push_back(mk_beat(3, 8'h80, 1'b1));
    rq[1].push_back(mk_beat(1, 8'h81, 1'b1));
    run_idle(30);
    chk("arst_first_tid", 256'(out_tid[0]), 256'(1));
    chk("arst_first_grant", 256'(grant_log[0]), 256'(4'b0010));

    // Packet counter wrap from 0xFFFF
    do_reset();
    tick();
    force dut.pkt_count_q = 16'hFFFF;
    tick();
    tick();
    release dut.pkt_count_q;
    tick();
    chk("wrap_preload", 256'(pkt_count), 256'(16'hFFFF));
    rq[2].push_back(mk_beat(2, 8'h90, 1'b1));
    run_idle(20);
    chk("wrap_count", 256'(pkt_count), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_noc_arbiter.md
AXIS_NOC_ARBITER -- requirements
Module: axis_noc_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of AXI-Stream requesters sharing the MVM NoC ingress port.
REQ-002 SHALL have parameter DATAW, default 128: tdata width.
REQ-003 SHALL have parameter IDW, default 4: tid width; SHALL be at least ceil(log2(NREQ)).
REQ-004 SHALL have parameter DESTW, default 12: tdest width.
REQ-005 SHALL have parameter USERW, default 75: tuser width.
REQ-006 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port s_tvalid, input, NREQ: per-requester valid.
REQ-009 SHALL have port s_tready, output, NREQ: per-requester ready.
REQ-010 SHALL have port s_tdata, input, NREQ*DATAW: requester i occupies bits [i*DATAW +: DATAW]. s_tdest (NREQ*DESTW) and s_tuser (NREQ*USERW) SHALL be packed the same way.
REQ-011 SHALL have port s_tlast, input, NREQ: per-requester end of packet.
REQ-012 SHALL have NoC-side outputs m_tvalid (1), m_tdata (DATAW), m_tlast (1), m_tid (IDW), m_tdest (DESTW) and m_tuser (USERW).
REQ-013 SHALL have port m_tready, input, 1: NoC ready.
REQ-014 SHALL have port grant, output, NREQ: one-hot current owner, all zero when idle.
REQ-015 SHALL have port pkt_count, output, 16: count of packets forwarded; wraps.

Function
REQ-016 SHALL implement an FSM with two states. IDLE: no owner. LOCKED: owner g holds the port.
REQ-017 In IDLE with any s_tvalid set, SHALL pick g as the first set bit searching upward, circularly, from last_grant+1. It SHALL register g and enter LOCKED on the next edge. In IDLE with no s_tvalid set, SHALL stay in IDLE.
REQ-018 In IDLE, s_tready SHALL be all zero. No beat is accepted in the arbitration cycle.
REQ-019 In LOCKED, s_tready[g] SHALL be (!m_tvalid || m_tready). All other s_tready bits SHALL be 0.
REQ-020 The output register SHALL load s_*[g] when s_tvalid[g] && s_tready[g]. m_tid SHALL be g, zero-extended.
REQ-021 m_tvalid SHALL clear after m_tready when no new beat is loaded in the same cycle. While m_tvalid && !m_tready, all m_* outputs SHALL hold stable.
REQ-022 Accepting a beat with s_tlast[g]=1 SHALL cause the following on that edge: return to IDLE, set last_grant <= g, and increment pkt_count by 1, modulo 2^16.
REQ-023 Throughput SHALL be 1 beat per clk inside a packet. Packet-to-packet gap SHALL be exactly 1 arbitration cycle.
REQ-024 Latency SHALL be 2 edges from s_tvalid rising in IDLE to the first m_tvalid, given m_tready=1.
REQ-025 The owner SHALL NOT change mid-packet. If s_tvalid[g] drops before tlast, the FSM SHALL stay LOCKED to g.
REQ-026 A requester with continuously asserted valid SHALL be granted within NREQ-1 other packets.
REQ-027 grant SHALL be one-hot of g in LOCKED and zero in IDLE.
REQ-028 In the last-beat cycle, the registered tlast beat SHALL drain normally on later m_tready, independent of the new FSM state.

Reset
REQ-029 While reset_n=0, asynchronously, SHALL set: state=IDLE, m_tvalid=0, m_tlast=0, m_tdata/m_tid/m_tdest/m_tuser=0, grant=0, pkt_count=0, last_grant=NREQ-1 (requester 0 has first priority).
REQ-030 Reset mid-packet SHALL discard the partial packet and any held output beat, with no further m_tvalid until a new grant.
REQ-031 reset_n deassertion is synchronised externally, so the first post-reset edge SHALL behave as a normal IDLE cycle.

Verification
REQ-032 Valid on requesters 0 and 2 simultaneously after reset, single-beat packets, m_tready=1: grant 0001 then 0100. m_tid sequence is 0, 2. pkt_count reaches 2.
REQ-033 Requester 1 sends 4 beats (tlast on beat 4), 0xA0..0xA3; requester 3 is valid throughout. Requester 3 SHALL receive no ready until 0xA3 is accepted. m_tdata order is A0, A1, A2, A3, then requester 3 data.
REQ-034 m_tready=0 for 5 cycles mid-packet: m_* outputs SHALL hold stable, s_tready[g]=0 while m_tvalid=1, and no beat is lost or duplicated.
REQ-035 All 4 requesters continuously valid with 1-beat packets: grant rotates 0,1,2,3,0. m_tvalid duty is 50% (1 idle cycle per packet).
REQ-036 reset_n pulsed low during beat 2 of a 3-beat packet: m_tvalid=0 and pkt_count=0 immediately. Next arbitration SHALL grant the lowest valid index.
REQ-037 Preload pkt_count to 0xFFFF (force or 65535 packets), then send one more packet: pkt_count SHALL wrap to 0x0000.
